instr_queue: RTL
================

INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 The block SHALL have parameter IW, default 16, meaning instruction word width in bits.
REQ-002 The block SHALL have parameter OPW, default 3, meaning opcode field width, taken from the top OPW bits of the word.
REQ-003 The block SHALL have parameter AW, default 6, meaning address field width, taken from the bottom AW bits of the word.
REQ-004 The block SHALL have parameter DEPTH, default 4, meaning number of queue entries; legal values are powers of two, 2 or greater.
REQ-005 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have the port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have the port ce, input, 1 bit: clock enable; all state is frozen while ce=0.
REQ-008 The block SHALL have the port flush, input, 1 bit: synchronous queue clear.
REQ-009 The block SHALL have the port in_valid, input, 1 bit: in_data holds an instruction to load.
REQ-010 The block SHALL have the port in_ready, output, 1 bit: the queue can accept a word.
REQ-011 The block SHALL have the port in_data, input, IW bits: instruction word.
REQ-012 The block SHALL have the port out_valid, output, 1 bit: the head entry is valid.
REQ-013 The block SHALL have the port out_ready, input, 1 bit: the consumer retires the head entry.
REQ-014 The block SHALL have the port code_op, output, OPW bits: opcode of the head entry.
REQ-015 The block SHALL have the port ADR_RI, output, AW bits: address field of the head entry.
REQ-016 The block SHALL have the port count, output, $clog2(DEPTH)+1 bits: number of valid entries.
REQ-017 The block SHALL have the port ovf, output, 1 bit: sticky overflow flag.

Function
REQ-018 The block SHALL evaluate the following events, each only while ce=1:
- push = in_valid & in_ready;
- pop = out_valid & out_ready;
- flush.
REQ-019 The block SHALL drive in_ready = (count < DEPTH) combinationally, independent of out_ready.
- A full queue refuses a push even when a pop occurs in the same cycle.
REQ-020 The block SHALL drive out_valid = (count != 0) combinationally.
REQ-021 The block SHALL drive code_op = head[IW-1 -: OPW] and ADR_RI = head[AW-1:0] combinationally from the head entry.
- When the queue is empty, both SHALL be 0.
REQ-022 On push, the block SHALL write in_data at the write pointer and advance the pointer modulo DEPTH.
REQ-023 On pop, the block SHALL advance the read pointer modulo DEPTH.
REQ-024 The block SHALL update count as follows:
- push and pop in the same cycle: count unchanged;
- push only: count + 1;
- pop only: count - 1.
REQ-025 The block SHALL have a latency of 1 cycle: a word pushed into an empty queue appears on out_valid, code_op and ADR_RI after the next rising edge.
REQ-026 The block SHALL treat entry storage as follows:
- Entry storage is not reset or cleared.
- Only pointers, count and ovf carry reset and flush values.
- Stale entries SHALL never be visible on the outputs.
REQ-027 The block SHALL set ovf when ce=1, in_valid=1 and in_ready=0.
- The refused word SHALL be dropped.
- ovf SHALL stay set until flush or reset.
REQ-028 Flush SHALL take priority over push, pop and ovf-set in the same cycle. On flush:
- pointers SHALL be set to 0;
- count SHALL be set to 0;
- ovf SHALL be cleared;
- in_valid and out_ready SHALL be ignored that cycle.
REQ-029 While ce=0, the block SHALL change no state.
- Outputs SHALL remain valid combinational functions of the held state.

Reset
REQ-030 While rst=0, the block SHALL immediately force pointers, count and ovf to 0, giving in_ready=1, out_valid=0, code_op=0 and ADR_RI=0.
REQ-031 Reset asserted mid-operation SHALL discard all queued entries.
- No push or pop SHALL take effect on the edge coinciding with reset release.

Verification
REQ-032 The bench SHALL cover single load: reset, then push 16'hA03F with ce=1, out_ready=0.
- Next cycle: out_valid=1, code_op=3'b101, ADR_RI=6'h3F, count=1.
REQ-033 The bench SHALL cover fill and overflow: push 4 words with out_ready=0.
- Then: count=4, in_ready=0.
- A fifth push leaves count=4 and sets ovf=1; the fifth word is never output.
REQ-034 The bench SHALL cover order and wrap-around: push 6 words over time, popping concurrently.
- Words exit in push order across pointer wrap.
- A simultaneous push and pop at count=2 leaves count=2.
REQ-035 The bench SHALL cover ce gating: with count=2, hold ce=0 and drive in_valid=1, out_ready=1 and flush=1 for 3 cycles.
- count, the head entry and ovf are unchanged.
REQ-036 The bench SHALL cover flush priority: with count=3 and ovf=1, assert flush, in_valid and out_ready together.
- Next cycle: count=0, out_valid=0, ovf=0, code_op=0.
REQ-037 The bench SHALL cover asynchronous reset: drop rst mid-cycle with count=2.
- Outputs clear before the next clock edge.
- After release, the first push appears with 1-cycle latency.

Source files
------------

// File: rtl/instr_queue.sv
// Instruction queue: DEPTH-entry circular FIFO of IW-bit words that exposes the
// head entry's opcode and address fields, with a sticky overflow flag.
module instr_queue #(
   parameter int IW    = 16,
   parameter int OPW   = 3,
   parameter int AW    = 6,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ce,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [IW-1:0]            in_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [OPW-1:0]           code_op,
   output logic [AW-1:0]            ADR_RI,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     ovf
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [IW-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [IW-1:0] head;
   logic          head_unused;
   logic          push;
   logic          pop;
   logic          refuse;

   // A full queue refuses a push even if the head is retired in the same cycle.
   assign in_ready  = (count < CW'(DEPTH));
   assign out_valid = (count != '0);

   // Flush masks every other event; nothing happens while ce is low.
   assign push   = ce & ~flush & in_valid & in_ready;
   assign pop    = ce & ~flush & out_valid & out_ready;
   assign refuse = ce & ~flush & in_valid & ~in_ready;

   // Stale storage is masked so an empty queue always shows zero fields.
   assign head        = mem[rd_ptr];
   assign head_unused = ^head;
   assign code_op     = out_valid ? head[IW-1 -: OPW] : '0;
   assign ADR_RI      = out_valid ? head[AW-1:0]      : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
      end else if (ce) begin
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
         end else begin
            if (push) begin
               wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
               rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
            if (refuse) begin
               ovf <= 1'b1;
            end
         end
      end
   end

endmodule
